// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int unsigned ARB_WDOG_W = 8;

endpackage

// File: rtl/mem_port_timer.sv
// Watchdog counter: synchronous clear, count enable, terminal-count flag.
module mem_port_timer
  import mips_mem_pkg::*;
#(
  parameter int unsigned WIDTH    = ARB_WDOG_W,
  parameter int unsigned TERMINAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign tc = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto the single-port unified memory.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise data always beats fetch.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t state_q, state_d;
  logic       grant_i, grant_d;
  logic       busy, finish, abort;
  logic       wdog_tc;
  logic       pick_i;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_q;

  // Resets to data so the first tie goes to fetch.
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      last_q <= OWN_D;
    end else if (grant_i) begin
      last_q <= OWN_I;
    end else if (grant_d) begin
      last_q <= OWN_D;
    end
  end

  assign pick_i = (last_q == OWN_D);
`else
  assign pick_i = 1'b0;
`endif

  assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        grant_i = if_req && (!d_req || pick_i);
        grant_d = d_req && !grant_i;
        if (grant_i) begin
          state_d = BUSY_I;
        end else if (grant_d) begin
          state_d = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack coinciding with the terminal count completes normally.
        if (mem_ack) begin
          finish  = 1'b1;
          state_d = RESP;
        end else if (wdog_tc) begin
          finish  = 1'b1;
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      if_err    <= 1'b0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if_done <= finish && (state_q == BUSY_I);
      if_err  <= abort && (state_q == BUSY_I);
      d_done  <= finish && (state_q == BUSY_D);
      d_err   <= abort && (state_q == BUSY_D);

      if (grant_i) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end else if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (finish) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      // Stores leave the load-data register untouched.
      if (busy && mem_ack) begin
        if (state_q == BUSY_I) begin
          if_rdata <= mem_rdata;
        end else if (!mem_we) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  mem_port_timer #(
    .WIDTH   (ARB_WDOG_W),
    .TERMINAL(TIMEOUT)
  ) u_wdog (
    .clk   (ref_clk),
    .rst   (reset),
    .clear (grant_i || grant_d),
    .enable(busy && !mem_ack),
    .tc    (wdog_tc)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 15;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        ref_clk = 1'b0;
  logic        reset   = 1'b0;
  logic        if_req  = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done, if_err;
  logic        d_req   = 1'b0;
  logic        d_we    = 1'b0;
  logic [31:0] d_addr  = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done, d_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        rsp_ack = 1'b0;
  logic        inj_ack = 1'b0;
  logic        mem_ack;

  assign mem_ack = rsp_ack | inj_ack;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .ref_clk  (ref_clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .d_err    (d_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 ref_clk = ~ref_clk;
  always @(posedge ref_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int          m_phase = 0;  // 0 idle, 1 memory access open, 2 response cycle
  int          m_owner = 0;  // 1 fetch, 2 data
  int          m_age   = 0;  // cycles since grant
  int          m_last  = 2;
  logic [31:0] e_if_rdata = '0, e_d_rdata = '0, e_addr = '0, e_wdata = '0;
  logic        e_we = 1'b0;
  logic        e_if_done = 1'b0, e_if_err = 1'b0, e_d_done = 1'b0, e_d_err = 1'b0;

  function automatic int pick(input logic fi, input logic fd, input int last);
    if (fi && fd) return RR ? ((last == 2) ? 1 : 2) : 2;
    return fi ? 1 : 2;
  endfunction

  always @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_owner <= 0; m_age <= 0; m_last <= 2;
      e_if_rdata <= '0; e_d_rdata <= '0; e_addr <= '0; e_wdata <= '0; e_we <= 1'b0;
      e_if_done <= 1'b0; e_if_err <= 1'b0; e_d_done <= 1'b0; e_d_err <= 1'b0;
    end else begin
      e_if_done <= 1'b0; e_if_err <= 1'b0; e_d_done <= 1'b0; e_d_err <= 1'b0;
      case (m_phase)
        0: if (if_req || d_req) begin
          m_owner <= pick(if_req, d_req, m_last);
          m_last  <= pick(if_req, d_req, m_last);
          m_phase <= 1;
          m_age   <= 0;
          if (pick(if_req, d_req, m_last) == 1) begin
            e_addr <= if_addr; e_we <= 1'b0;
          end else begin
            e_addr <= d_addr; e_we <= d_we; e_wdata <= d_wdata;
          end
        end
        1: begin
          m_age <= m_age + 1;
          if (mem_ack) begin
            m_phase <= 2;
            if (m_owner == 1) begin
              e_if_done <= 1'b1; e_if_rdata <= mem_rdata;
            end else begin
              e_d_done <= 1'b1;
              if (!e_we) e_d_rdata <= mem_rdata;
            end
          end else if (m_age + 1 == TO + 1) begin
            m_phase <= 2;
            if (m_owner == 1) begin
              e_if_done <= 1'b1; e_if_err <= 1'b1;
            end else begin
              e_d_done <= 1'b1; e_d_err <= 1'b1;
            end
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge ref_clk) begin
    chk("mem_req", mem_req, m_phase == 1);
    chk("if_done", if_done, e_if_done);
    chk("if_err", if_err, e_if_err);
    chk("d_done", d_done, e_d_done);
    chk("d_err", d_err, e_d_err);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    if (m_phase == 1 || reset) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      if (m_owner == 2 || reset) chk("mem_wdata", mem_wdata, e_wdata);
    end
  end

  // ---------------- memory responder ----------------
  int          rsp_wait = 0;  // -1 = never acknowledge
  logic [31:0] rsp_data = '0;
  int          wcnt     = 0;

  initial begin
    forever begin
      @(posedge ref_clk);
      #1;
      rsp_ack = 1'b0;
      mem_rdata = 32'hBAD0_0000 | 32'(wcnt);
      if (mem_req && !reset) begin
        if (rsp_wait >= 0 && wcnt == rsp_wait) begin
          rsp_ack = 1'b1;
          mem_rdata = rsp_data;
        end
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  int we_cycles = 0;
  always @(negedge ref_clk) begin
    if (mem_req && mem_we && mem_addr == 32'h100 && mem_wdata == 32'hDEAD_BEEF) we_cycles++;
  end

  task automatic wait_done(input int limit, output int who, output int at);
    who = 0;
    at  = 0;
    for (int i = 0; i < limit && who == 0; i++) begin
      @(negedge ref_clk);
      if (if_done) begin
        who = 1; at = cyc;
      end else if (d_done) begin
        who = 2; at = cyc;
      end
    end
    n_cmp++;
    if (who == 0) begin
      n_fail++;
      $display("FAIL done_wait: got no done, want done within %0d cycles", limit);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish, want finish before 50000");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int who, at, c0, g, ndone;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_done", d_done, 1'b0);

    // Fetch alone, two wait states.
    rsp_wait = 2;
    rsp_data = 32'h2402_0005;
    if_req = 1'b1;
    if_addr = 32'h0000_0040;
    c0 = cyc;
    wait_done(10, who, at);
    chk("fetch_owner", 64'(who), 64'd1);
    chk("fetch_latency", 64'(at - c0), 64'd4);
    chk("fetch_rdata", if_rdata, 32'h2402_0005);
    chk("fetch_err", if_err, 1'b0);
    tick();
    if_req = 1'b0;
    chk("fetch_pulse_width", if_done, 1'b0);
    tick();

    // Store alone, zero wait.
    rsp_wait = 0;
    rsp_data = 32'h1111_1111;
    we_cycles = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    wait_done(10, who, at);
    chk("store_owner", 64'(who), 64'd2);
    chk("store_we_cycles", 64'(we_cycles), 64'd1);
    chk("store_rdata_kept", d_rdata, 32'h0);
    chk("store_err", d_err, 1'b0);
    tick();
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Both requesting for four accesses.
    rsp_wait = 1;
    rsp_data = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_addr = 32'h204;
    for (int k = 0; k < 4; k++) begin
      wait_done(12, who, at);
      chk($sformatf("tie_grant%0d", k), 64'(who), RR ? ((k % 2 == 0) ? 64'd1 : 64'd2) : 64'd2);
    end
    tick();
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // Memory never acknowledges.
    rsp_wait = -1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    g = 0;
    for (int i = 0; i < 5 && g == 0; i++) begin
      @(negedge ref_clk);
      if (mem_req) g = cyc;
    end
    chk("tmo_granted", 64'(g != 0), 64'd1);
    wait_done(30, who, at);
    chk("tmo_owner", 64'(who), 64'd2);
    chk("tmo_latency", 64'(at - g), 64'd16);
    chk("tmo_err", d_err, 1'b1);
    tick();
    d_req = 1'b0;
    tick();
    tick();
    inj_ack = 1'b1;
    tick();
    inj_ack = 1'b0;
    ndone = 0;
    repeat (4) begin
      @(negedge ref_clk);
      if (if_done || d_done) ndone++;
    end
    chk("late_ack_ignored", 64'(ndone), 64'd0);

    // Reset in the middle of a fetch.
    tick();
    if_req = 1'b1; if_addr = 32'h80;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("rst_async_mem_req", mem_req, 1'b0);
    chk("rst_async_if_rdata", if_rdata, 32'h0);
    if_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    rsp_wait = 0;
    rsp_data = 32'hCAFE_0001;
    tick();
    if_req = 1'b1; if_addr = 32'h84;
    c0 = cyc;
    wait_done(10, who, at);
    chk("refetch_owner", 64'(who), 64'd1);
    chk("refetch_latency", 64'(at - c0), 64'd2);
    chk("refetch_rdata", if_rdata, 32'hCAFE_0001);
    tick();
    if_req = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single-port unified memory between the instruction-fetch stage and the load/store stage. Each requester uses a req/done handshake. The arbiter registers the winning request onto the memory port and waits a variable number of cycles for `mem_ack`. It then returns read data and a one-cycle `done` pulse to the owner, and a watchdog aborts accesses the memory never acknowledges. It sits between the processor core and the memory model, driven by `ref_clk`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 15, max wait cycles in a busy state before abort (1..255)

- `ref_clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high; one clock, no other clock or reset
- `if_req`  in  1  fetch request, held until `if_done`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word, registered
- `if_done`  out  1  one-cycle completion pulse
- `if_err`  out  1  qualifies `if_done`: access timed out
- `d_req`  in  1  load/store request, held until `d_done`
- `d_we`  in  1  1 = store
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, registered
- `d_done`, `d_err`  out  1 each  as for fetch
- `mem_req`  out  1  memory access valid, registered
- `mem_we`  out  1  write strobe, registered
- `mem_addr`  out  ADDR_W  registered address
- `mem_wdata`  out  DATA_W  registered write data
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`
- `mem_ack`  in  1  access complete

## Operation
- States:
  - IDLE: samples `if_req`/`d_req`; one requester → that BUSY state.
  - BUSY_I / BUSY_D: `mem_*` driven from captured request; `mem_ack` → RESP.
  - RESP: owner's `done` high → IDLE.
- IDLE arbitration when both request: see Configuration.
- On grant, capture owner's address, `we` (0 for fetch) and wdata into `mem_*` registers; hold them stable until leaving BUSY.
- On `mem_ack` in BUSY: latch `mem_rdata` into the owner's rdata register (loads and fetches only; stores leave rdata unchanged). `err` = 0.
- Watchdog: 8-bit counter cleared on entering BUSY, incremented each BUSY cycle without ack.
  - At count == TIMEOUT: → RESP with owner's `err` = 1; rdata unchanged.
  - Ack arriving in the same cycle as timeout: the ack wins.
- `mem_ack` in IDLE or RESP is ignored (a late ack after abort is dropped).
- Requests are not sampled in RESP, giving a mandatory one-cycle turnaround. The requester drops `req` on the cycle after `done`, or re-holds it for a new access.
- `reset` (any time, including mid-access): immediately forces IDLE. All outputs go to 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, rdata registers, `done`, `err`. Round-robin pointer resets to "data last served", so fetch wins first tie.

## Timing
- Request high in IDLE at edge N → `mem_req`=1 from edge N.
- Zero-wait memory (`mem_ack` during first BUSY cycle): `done` in cycle N+1, IDLE at N+2.
- Minimum spacing between grants is 3 cycles.
- k wait cycles add k cycles of latency.
- Timeout: `done`/`err` assert TIMEOUT+1 cycles after grant.
- `done` and `err` are registered outputs, exactly one cycle wide.
- `mem_req` deasserts in RESP.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a tie, grant the requester not served last. A last-owner register is updated on every grant.
- Undefined: fixed priority, data always beats fetch (load/store completes before the next fetch). Last-owner register is not built.

## Structure
- Package `mips_mem_pkg`:
  - `arb_state_t` enum: IDLE, BUSY_I, BUSY_D, RESP
  - `arb_owner_t` enum: OWN_I, OWN_D
  - watchdog width constant `ARB_WDOG_W` = 8
- One sub-module `mem_port_timer`: clear/enable/terminal-count watchdog counter, async reset.
- Everything else in `mem_port_arbiter`.

## Test plan
- Fetch alone, addr 0x0000_0040, memory acks with 0x2402_0005 after 2 waits → `if_rdata`=0x2402_0005, `if_done` one pulse 4 cycles after request, `if_err`=0.
- Store alone, addr 0x100, wdata 0xDEAD_BEEF, zero-wait → `mem_we`=1 with those values for 1 cycle; `d_done` pulse; `d_rdata` unchanged.
- Both request simultaneously for 4 consecutive accesses:
  - round-robin build: grants I, D, I, D.
  - fixed build: all D while `d_req` held.
- Memory never acks, TIMEOUT=15 → `d_done`=`d_err`=1 at cycle 16 after grant. Ack injected later in IDLE is ignored, no `done`.
- `reset` asserted mid BUSY_I → `mem_req` low before next edge, no `if_done`. After release, fetch re-request completes normally.
